// File: rtl/sccpu_dbg_pkg.sv
// Shared types and constants for the single-cycle CPU debug monitor.
// Holds the monitor state encoding, the halt cause codes, the dump header
// length and a helper for sizing breakpoint index fields.
package sccpu_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_HDR_PC    = 3'd2,
        ST_HDR_INSTR = 3'd3,
        ST_DUMP      = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_BP   = 2'd1;
    localparam logic [1:0] CAUSE_LIM  = 2'd2;

    // PC beat + instruction beat ahead of the register beats
    localparam int unsigned HDR_BEATS = 2;

    // Register select is fixed at 5 bits (up to 32 registers)
    localparam int unsigned REG_SEL_W = 5;

    // Index width that stays at least 1 bit for a single comparator
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sccpu_bp_match.sv
// PC breakpoint comparator bank with lowest-index priority encoding.
// Ports:
//   pc_i      - current CPU PC
//   bp_addr_i - packed breakpoint addresses, slice k = breakpoint k
//   bp_en_i   - per-breakpoint enable
//   hit_o     - any enabled breakpoint matches pc_i (combinational)
//   hit_idx_o - lowest matching index, 0 when no match (combinational)
module sccpu_bp_match
    import sccpu_dbg_pkg::*;
#(
    parameter int unsigned NUM_BP = 2,
    parameter int unsigned DW     = 32,
    parameter int unsigned IDX_W  = idx_width(NUM_BP)
) (
    input  logic [DW-1:0]        pc_i,
    input  logic [NUM_BP*DW-1:0] bp_addr_i,
    input  logic [NUM_BP-1:0]    bp_en_i,
    output logic                 hit_o,
    output logic [IDX_W-1:0]     hit_idx_o
);

    // Scan from the top down so the lowest matching index is written last
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int k = int'(NUM_BP) - 1; k >= 0; k--) begin
            if (bp_en_i[k] && (pc_i == bp_addr_i[k*DW +: DW])) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/sccpu_dbg_monitor.sv
// Debug monitor for the single-cycle CPU: halts on a PC breakpoint or cycle
// limit, then streams PC, instruction and rf[0..NREG-1] over a valid/ready
// dump port while walking the register-file read select.
// Ports:
//   clk, rstn            - clock, synchronous active-low reset
//   arm_i                - start from IDLE or resume (step-over) from DONE
//   pc_i, instr_i        - CPU PC and instruction for the current cycle
//   bp_addr_i, bp_en_i   - breakpoint addresses and enables
//   cyc_limit_i          - cycle limit, 0 disables
//   cpu_halt_o           - freezes PC/RF/memory updates
//   reg_sel_o/reg_data_i - register-file read port driven during the dump
//   dump_*               - dump stream (valid/ready/data/last)
//   cause_o, hit_idx_o   - halt cause and lowest matching breakpoint
//   done_o               - dump complete
module sccpu_dbg_monitor
    import sccpu_dbg_pkg::*;
#(
    parameter  int unsigned NUM_BP = 2,
    parameter  int unsigned CYC_W  = 16,
    parameter  int unsigned NREG   = 32,
    parameter  int unsigned DW     = 32,
    localparam int unsigned IDX_W  = idx_width(NUM_BP)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  arm_i,
    input  logic [DW-1:0]         pc_i,
    input  logic [DW-1:0]         instr_i,
    input  logic [NUM_BP*DW-1:0]  bp_addr_i,
    input  logic [NUM_BP-1:0]     bp_en_i,
    input  logic [CYC_W-1:0]      cyc_limit_i,
    output logic                  cpu_halt_o,
    output logic [REG_SEL_W-1:0]  reg_sel_o,
    input  logic [DW-1:0]         reg_data_i,
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [DW-1:0]         dump_data_o,
    output logic                  dump_last_o,
    output logic [1:0]            cause_o,
    output logic [IDX_W-1:0]      hit_idx_o,
    output logic                  done_o
);

    localparam logic [REG_SEL_W-1:0] LAST_REG = REG_SEL_W'(NREG - 1);

    state_e               state_q, state_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic [1:0]           cause_q, cause_d;
    logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
    logic [REG_SEL_W-1:0] beat_q, beat_d;
    logic                 skip_q, skip_d;
    logic [DW-1:0]        pc_cap_q, pc_cap_d;
    logic [DW-1:0]        instr_cap_q, instr_cap_d;

    logic                 bp_match;
    logic [IDX_W-1:0]     bp_idx;
    logic                 hit_bp;
    logic                 hit_lim;
    logic                 run_hit;
    logic                 xfer;

    sccpu_bp_match #(
        .NUM_BP (NUM_BP),
        .DW     (DW),
        .IDX_W  (IDX_W)
    ) u_bp_match (
        .pc_i      (pc_i),
        .bp_addr_i (bp_addr_i),
        .bp_en_i   (bp_en_i),
        .hit_o     (bp_match),
        .hit_idx_o (bp_idx)
    );

    // Trigger conditions; skip masks breakpoints for the step-over cycle
    assign hit_bp  = bp_match && !skip_q;
    assign hit_lim = (cyc_limit_i != '0) && (cyc_q == cyc_limit_i);
    assign run_hit = (state_q == ST_RUN) && (hit_bp || hit_lim);
    assign xfer    = dump_valid_o && dump_ready_i;

    // Next-state logic for FSM, cycle counter, capture and beat sequencer
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        cause_d     = cause_q;
        hit_idx_d   = hit_idx_q;
        beat_d      = beat_q;
        skip_d      = skip_q;
        pc_cap_d    = pc_cap_q;
        instr_cap_d = instr_cap_q;

        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    state_d   = ST_RUN;
                    cyc_d     = '0;
                    cause_d   = CAUSE_NONE;
                    hit_idx_d = '0;
                    skip_d    = 1'b0;
                end
            end
            ST_RUN: begin
                skip_d = 1'b0;
                if (hit_bp || hit_lim) begin
                    state_d     = ST_HDR_PC;
                    pc_cap_d    = pc_i;
                    instr_cap_d = instr_i;
                    cause_d     = hit_bp ? CAUSE_BP : CAUSE_LIM;
                    hit_idx_d   = hit_bp ? bp_idx : '0;
                    beat_d      = '0;
                end else if (cyc_q != '1) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_HDR_PC: begin
                if (xfer) state_d = ST_HDR_INSTR;
            end
            ST_HDR_INSTR: begin
                if (xfer) begin
                    state_d = ST_DUMP;
                    beat_d  = '0;
                end
            end
            ST_DUMP: begin
                // beat_q only advances on a transfer, so reg_sel holds under stall
                if (xfer) begin
                    if (beat_q == LAST_REG) begin
                        state_d = ST_DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + REG_SEL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (arm_i) begin
                    state_d   = ST_RUN;
                    cyc_d     = '0;
                    cause_d   = CAUSE_NONE;
                    hit_idx_d = '0;
                    skip_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            cause_q     <= CAUSE_NONE;
            hit_idx_q   <= '0;
            beat_q      <= '0;
            skip_q      <= 1'b0;
            pc_cap_q    <= '0;
            instr_cap_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            cause_q     <= cause_d;
            hit_idx_q   <= hit_idx_d;
            beat_q      <= beat_d;
            skip_q      <= skip_d;
            pc_cap_q    <= pc_cap_d;
            instr_cap_q <= instr_cap_d;
        end
    end

    // Halt is immediate on a RUN hit so the matching instruction never retires
    assign cpu_halt_o   = run_hit
                        || (state_q == ST_HDR_PC) || (state_q == ST_HDR_INSTR)
                        || (state_q == ST_DUMP)   || (state_q == ST_DONE);
    assign dump_valid_o = (state_q == ST_HDR_PC) || (state_q == ST_HDR_INSTR)
                        || (state_q == ST_DUMP);
    assign dump_last_o  = (state_q == ST_DUMP) && (beat_q == LAST_REG);
    assign done_o       = (state_q == ST_DONE);
    assign reg_sel_o    = beat_q;
    assign cause_o      = cause_q;
    assign hit_idx_o    = hit_idx_q;

    // Payload select; register beats pass the async RF read of reg_sel_o
    always_comb begin
        dump_data_o = '0;
        case (state_q)
            ST_HDR_PC:    dump_data_o = pc_cap_q;
            ST_HDR_INSTR: dump_data_o = instr_cap_q;
            ST_DUMP:      dump_data_o = reg_data_i;
            default:      dump_data_o = '0;
        endcase
    end

endmodule
